// File: rtl/tempsens_core_emu_pkg.sv
// Shared tempsens definitions: state encodings and DAC code limits, also used by
// the controller's debug decode of o_state.
package tempsens_core_emu_pkg;

    localparam int                    TS_N_VDAC = 6;
    localparam logic [TS_N_VDAC-1:0] TS_VMAX   = 6'd63;
    localparam logic [TS_N_VDAC-1:0] TS_VMIN   = 6'd0;

    typedef enum logic [1:0] {
        ST_IDLE      = 2'd0,
        ST_CHARGED   = 2'd1,
        ST_DISCHARGE = 2'd2,
        ST_EMPTY     = 2'd3
    } ts_state_e;

    // The emulated node reads as charged until the discharge completes.
    function automatic logic ts_is_charged(input ts_state_e state);
        logic result;
        case (state)
            ST_CHARGED:   result = 1'b1;
            ST_DISCHARGE: result = 1'b1;
            default:      result = 1'b0;
        endcase
        return result;
    endfunction

endpackage

// File: rtl/tempsens_core_emu_rate.sv
// Phase accumulator that produces discharge ticks.
// A higher DAC code gives a smaller increment, so ticks are spaced further apart.
module tempsens_core_emu_rate
    import tempsens_core_emu_pkg::*;
#(
    parameter int N_VDAC = 6
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [N_VDAC-1:0] i_dat,
    input  logic              i_clr,
    input  logic              i_run,
    output logic              o_carry
);

    localparam logic [N_VDAC-1:0] VMAX = {N_VDAC{1'b1}};

    logic [N_VDAC-1:0] r_acc;
    logic [N_VDAC-1:0] w_inc;
    logic [N_VDAC:0]   w_sum;

    // Increment ranges from 1 (dat=VMAX) to 2^N_VDAC (dat=0).
    always_comb begin
        w_inc   = VMAX - i_dat;
        w_sum   = {1'b0, r_acc} + {1'b0, w_inc} + {{N_VDAC{1'b0}}, 1'b1};
        o_carry = i_run & w_sum[N_VDAC];
    end

    // Accumulator register: cleared outside discharge, advanced while running.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_acc <= {N_VDAC{1'b0}};
        end else if (i_clr) begin
            r_acc <= {N_VDAC{1'b0}};
        end else if (i_run) begin
            r_acc <= w_sum[N_VDAC-1:0];
        end
    end

endmodule

// File: rtl/tempsens_core_emu.sv
// Digital stand-in for the analog temperature-dependent delay line.
// It answers the controller's precharge/measure drive with a tempdelay pulse.
module tempsens_core_emu
    import tempsens_core_emu_pkg::*;
#(
    parameter int N_VDAC = 6,
    parameter int N_DLY  = 12
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              i_ts_en,
    input  logic [N_VDAC-1:0] i_ts_dat,
    input  logic              i_ts_prechrgn,
    input  logic [N_DLY-1:0]  i_base_dly,
    output logic              o_ts_tempdelay,
    output logic [1:0]        o_state,
    output logic              o_err
);

    localparam logic [N_DLY-1:0] CNT_ONE = {{(N_DLY-1){1'b0}}, 1'b1};

    ts_state_e        r_state;
    ts_state_e        w_state_nxt;
    logic [N_DLY-1:0] r_cnt;
    logic [N_DLY-1:0] w_cnt_nxt;
    logic             r_err;
    logic             w_err_nxt;
    logic             r_tempdelay;
    logic             w_carry;
    logic             w_clr;
    logic             w_run;

    assign w_clr = (r_state != ST_DISCHARGE);
    assign w_run = (r_state == ST_DISCHARGE) & i_ts_en & i_ts_prechrgn;

    tempsens_core_emu_rate #(
        .N_VDAC (N_VDAC)
    ) u_rate (
        .clk     (clk),
        .reset   (reset),
        .i_dat   (i_ts_dat),
        .i_clr   (w_clr),
        .i_run   (w_run),
        .o_carry (w_carry)
    );

    // Next-state, discharge counter and protocol-error logic.
    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        w_err_nxt   = r_err;
        if (!i_ts_en) begin
            w_state_nxt = ST_IDLE;
        end else if (!i_ts_prechrgn) begin
            w_state_nxt = ST_CHARGED;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    w_state_nxt = ST_IDLE;
                    w_err_nxt   = 1'b1;
                end
                ST_CHARGED: begin
                    w_state_nxt = ST_DISCHARGE;
                    w_cnt_nxt   = i_base_dly;
                end
                ST_DISCHARGE: begin
                    // A loaded count of 0 ends on the first carry, same as 1.
                    if (w_carry) begin
                        if (r_cnt <= CNT_ONE) begin
                            w_state_nxt = ST_EMPTY;
                        end else begin
                            w_cnt_nxt = r_cnt - CNT_ONE;
                        end
                    end else begin
                        w_cnt_nxt = r_cnt;
                    end
                end
                ST_EMPTY: begin
                    w_state_nxt = ST_EMPTY;
                end
                default: begin
                    w_state_nxt = ST_IDLE;
                end
            endcase
        end
    end

    // State, counter and registered outputs.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state     <= ST_IDLE;
            r_cnt       <= {N_DLY{1'b0}};
            r_err       <= 1'b0;
            r_tempdelay <= 1'b0;
        end else begin
            r_state     <= w_state_nxt;
            r_cnt       <= w_cnt_nxt;
            r_err       <= w_err_nxt;
            r_tempdelay <= ts_is_charged(w_state_nxt);
        end
    end

    assign o_ts_tempdelay = r_tempdelay;
    assign o_state        = r_state;
    assign o_err          = r_err;

endmodule

// File: tb/tb_tempsens_core_emu.sv
// Directed bench for tempsens_core_emu: emulates the controller drive sequence
// and measures the number of discharge cycles.
module tb_tempsens_core_emu;

    localparam int LIMIT = 8000;

    logic        clk;
    logic        reset;
    logic        en;
    logic [5:0]  dat;
    logic        pre;
    logic [11:0] bdly;
    logic        tempdelay;
    logic [1:0]  state;
    logic        err;

    int checks   = 0;
    int failures = 0;

    typedef struct {
        logic [11:0] base;
        logic [5:0]  code;
        int          exp_t;
    } vec_t;

    vec_t vecs[7];

    tempsens_core_emu #(.N_VDAC(6), .N_DLY(12)) dut (
        .clk            (clk),
        .reset          (reset),
        .i_ts_en        (en),
        .i_ts_dat       (dat),
        .i_ts_prechrgn  (pre),
        .i_base_dly     (bdly),
        .o_ts_tempdelay (tempdelay),
        .o_state        (state),
        .o_err          (err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic go_idle();
        @(negedge clk);
        en  = 1'b0;
        pre = 1'b0;
    endtask

    // Precharge one cycle, arm with dat=0, then apply the measurement code.
    task automatic start_dis(input logic [11:0] base, input logic [5:0] code);
        @(negedge clk);
        en   = 1'b1;
        pre  = 1'b0;
        dat  = 6'd0;
        bdly = base;
        @(negedge clk);
        pre = 1'b1;
        @(negedge clk);
        dat = code;
    endtask

    task automatic count_cycles(output int n);
        n = 0;
        while (n < LIMIT) begin
            @(posedge clk);
            #1;
            n++;
            if (!tempdelay) break;
        end
    endtask

    initial begin
        int n;
        vecs[0] = '{12'd100, 6'd0,  100};
        vecs[1] = '{12'd100, 6'd32, 200};
        vecs[2] = '{12'd100, 6'd48, 400};
        vecs[3] = '{12'd100, 6'd63, 6400};
        vecs[4] = '{12'd0,   6'd0,  1};
        vecs[5] = '{12'd1,   6'd0,  1};
        vecs[6] = '{12'd3,   6'd16, 4};

        reset = 1'b1;
        en    = 1'b0;
        pre   = 1'b0;
        dat   = 6'd0;
        bdly  = 12'd0;
        #22;
        check("reset_tempdelay", int'(tempdelay), 0);
        check("reset_state", int'(state), 0);
        check("reset_err", int'(err), 0);
        @(negedge clk);
        reset = 1'b0;

        foreach (vecs[i]) begin
            go_idle();
            start_dis(vecs[i].base, vecs[i].code);
            count_cycles(n);
            check($sformatf("vec%0d_cycles", i), n, vecs[i].exp_t);
            check($sformatf("vec%0d_state_empty", i), int'(state), 3);
            check($sformatf("vec%0d_err", i), int'(err), 0);
        end

        // Re-precharge mid-discharge reloads count from current base and clears acc.
        go_idle();
        start_dis(12'd100, 6'd48);
        repeat (2) @(negedge clk);
        pre  = 1'b0;
        bdly = 12'd5;
        @(posedge clk);
        #1;
        check("abort_state_charged", int'(state), 1);
        check("abort_tempdelay", int'(tempdelay), 1);
        @(negedge clk);
        pre = 1'b1;
        dat = 6'd0;
        @(negedge clk);
        dat  = 6'd32;
        bdly = 12'd200;
        count_cycles(n);
        check("abort_reload_cycles", n, 10);

        // en=0 mid-discharge returns to IDLE on the next edge.
        go_idle();
        start_dis(12'd100, 6'd0);
        repeat (5) @(negedge clk);
        en = 1'b0;
        @(posedge clk);
        #1;
        check("en0_state", int'(state), 0);
        check("en0_tempdelay", int'(tempdelay), 0);

        // Asynchronous reset mid-discharge, observed before the next edge.
        go_idle();
        start_dis(12'd100, 6'd0);
        repeat (5) @(negedge clk);
        check("pre_async_tempdelay", int'(tempdelay), 1);
        #2;
        reset = 1'b1;
        #1;
        check("async_tempdelay", int'(tempdelay), 0);
        check("async_state", int'(state), 0);
        @(negedge clk);
        reset = 1'b0;
        en    = 1'b0;
        pre   = 1'b0;

        // Measure without precharge from IDLE flags a sticky error.
        @(negedge clk);
        en  = 1'b1;
        pre = 1'b1;
        @(posedge clk);
        #1;
        check("err_set", int'(err), 1);
        check("err_tempdelay", int'(tempdelay), 0);
        check("err_state", int'(state), 0);
        start_dis(12'd2, 6'd0);
        count_cycles(n);
        check("err_valid_cycles", n, 2);
        check("err_sticky", int'(err), 1);
        @(negedge clk);
        reset = 1'b1;
        #1;
        check("err_cleared", int'(err), 0);
        @(negedge clk);
        reset = 1'b0;

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
